// File: rtl/me_search_ctrl.sv
// Full-search motion-estimation sequencer: walks the vertical offsets of one
// search window, strobing the comparator per row and capturing the winning MV.
module me_search_ctrl #(
  parameter int ROWS    = 16,
  parameter int ROW_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             row_req,
  output logic [ROW_W-1:0] row_idx,
  input  logic             row_valid,
  output logic             compare,
  output logic [ROW_W-1:0] mv_vertical,
  input  logic [3:0]       cmp_mvx,
  input  logic [3:0]       cmp_mvy,
  output logic [3:0]       mvx_out,
  output logic [3:0]       mvy_out,
  output logic [15:0]      blk_count
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, CMP, FLUSH, DONE} state_t;

  state_t           state;
  logic [ROW_W-1:0] row_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  // Row index and comparator offset both track the row counter, which only
  // moves on the CMP->REQ edge and is therefore stable from REQ through CMP.
  assign row_idx     = row_cnt;
  assign mv_vertical = row_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      tmo_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      row_req   <= 1'b0;
      compare   <= 1'b0;
      mvx_out   <= '0;
      mvy_out   <= '0;
      blk_count <= '0;
    end else begin
      // NOTE: non-blocking throughout; strobes default low so each is set only
      // on the transition into its own state and lasts exactly one cycle.
      row_req <= 1'b0;
      compare <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= REQ;
            busy    <= 1'b1;
            row_req <= 1'b1;
            row_cnt <= '0;
            err     <= 1'b0;
          end
        end
        REQ: begin
          state   <= WAIT;
          tmo_cnt <= '0;
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A valid row wins over a timeout landing in the same cycle.
          if (row_valid) begin
            state   <= CMP;
            compare <= 1'b1;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        CMP: begin
          if (row_cnt == ROW_W'(ROWS - 1)) begin
            state <= FLUSH;
          end else begin
            state   <= REQ;
            row_req <= 1'b1;
            row_cnt <= row_cnt + 1'b1;
          end
        end
        FLUSH: begin
          // Comparator has registered the last row by now.
          mvx_out   <= cmp_mvx;
          mvy_out   <= cmp_mvy;
          blk_count <= blk_count + 1'b1;
          state     <= DONE;
          done      <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/me_search_ctrl.md
Name: me_search_ctrl

Overview:
- Sequencer for one full-search motion-estimation pass over a 16x16 candidate window.
- Requests MAD rows one vertical offset at a time from the PE/MAD array and waits for each row to become valid.
- Fires the comparator's compare strobe with the matching mv_vertical, then captures the comparator's winning (mvx, mvy) after the last row.
- Sits between the block-level top controller (start/done) and the MAD array + comparator pair.

Parameters:
- ROWS, 16, number of vertical offsets per search; must be ≤ 2^ROW_W.
- ROW_W, 4, width of the row index and of mv_vertical.
- TIMEOUT, 255, maximum WAIT cycles per row before the pass is aborted with err.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a search pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a pass, success or abort.
- err  out  1  sticky; set on a row timeout, cleared when the next start is accepted.
- row_req  out  1  one-cycle request to the MAD array for row row_idx.
- row_idx  out  ROW_W  row being requested; held stable from REQ through CMP.
- row_valid  in  1  MAD array reports the requested row is present on the comparator input bus.
- compare  out  1  comparator enable; one-cycle pulse per row.
- mv_vertical  out  ROW_W  vertical offset presented to the comparator; equals row_idx.
- cmp_mvx  in  4  comparator's registered best horizontal MV.
- cmp_mvy  in  4  comparator's registered best vertical MV.
- mvx_out  out  4  final horizontal MV of the last successful pass.
- mvy_out  out  4  final vertical MV of the last successful pass.
- blk_count  out  16  count of successfully completed passes; wraps at 0xFFFF to 0.

Behaviour:
- Reset (synchronous): state IDLE, row counter 0, timeout counter 0. All outputs 0: busy, done, err, row_req, row_idx, compare, mv_vertical, mvx_out, mvy_out, blk_count.
- Reset mid-pass: IDLE on the next edge. compare and row_req are low from that edge; no partial result is captured.
- FSM states: IDLE, REQ, WAIT, CMP, FLUSH, DONE.
- IDLE:
  - start=1 → REQ; row counter := 0, err := 0.
  - start=0 → stay in IDLE.
- REQ: row_req=1 for exactly one cycle; timeout counter := 0; → WAIT.
- WAIT:
  - row_valid=1 → CMP.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT with row_valid still 0 → DONE with err := 1.
  - row_valid arriving in the same cycle the counter reaches TIMEOUT counts as valid (→ CMP, no error).
- CMP:
  - compare=1 and mv_vertical=row counter for exactly one cycle.
  - Row counter = ROWS-1 → FLUSH; otherwise row counter +1 → REQ.
- FLUSH: one idle cycle so the comparator's final registered update is visible. At the end of FLUSH: mvx_out := cmp_mvx, mvy_out := cmp_mvy, blk_count +1. → DONE.
- DONE:
  - done=1 for one cycle; → IDLE.
  - An aborted pass leaves mvx_out, mvy_out and blk_count unchanged.
- Row ordering: rows are issued strictly 0..ROWS-1. The row-0 compare must come first, because it is the one that reinitialises the comparator's minimum.
- Strobe outputs (compare, row_req, done) are decoded so they are high only in their own state. mv_vertical and row_idx may be registered copies of the row counter.
- Latency: with row_valid high in the first WAIT cycle, each row takes 3 cycles (REQ, WAIT, CMP). done is high in the 50th cycle after the edge that samples start (16×3 + FLUSH + DONE).
- Ignored inputs:
  - start while busy is ignored; it is not queued.
  - row_valid outside WAIT is ignored.
- Back-to-back passes: start held high through DONE is accepted in the IDLE cycle that follows, so there is one IDLE cycle between passes.

Test Plan:
- Reset, then start pulse; row_valid returned 1 cycle after each row_req; comparator model picks mad minimum at x=7, y=11 → exactly 16 compare pulses with mv_vertical 0..15 in order; done in cycle 50; mvx_out=7, mvy_out=11; blk_count=1; err=0.
- Random row_valid delay 0..20 cycles per row → compare pulses only in the cycle after row_valid, row_idx stable from REQ through CMP, correct final MV; done cycle = sum of delays + 50.
- TIMEOUT=8, row_valid withheld on row 5 → exactly 5 compare pulses (rows 0-4); err=1 and done=1 after 8 WAIT cycles; mvx_out, mvy_out and blk_count unchanged. The next start clears err.
- start pulsed repeatedly during a pass → ignored; a single done; blk_count +1 only.
- rst asserted while in WAIT of row 9 → next cycle busy=0, compare=0, all outputs 0; a new start runs a full 16-row pass.
- blk_count preloaded near wrap (0xFFFF via 65535 passes or force) plus one pass → blk_count=0x0000; start held high continuously → passes back-to-back with one IDLE cycle between done pulses.
